// File: rtl/imem_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to an in-order, variable-latency
// instruction memory and presents {pc, word} to IF. Optional macro: IMEM_PREFETCH_BYPASS_EN.
module imem_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] stale;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   hold_inst;
    logic [31:0]   hold_pc;

    logic [CW:0]   occupancy;
    logic          req_acc;
    logic          resp;
    logic          resp_live;
    logic          byp_take;
    logic          fifo_valid;
    logic          pop;
    logic          push;
    logic [31:0]   redirect_aligned;

    // Both handshakes are valid/ready style: a transfer happens in a cycle where the
    // producer's valid (mem_req / inst_valid) and the consumer's ready (mem_gnt /
    // inst_ready) are both high; a raised mem_req keeps mem_addr stable until granted
    // unless redirect or reset withdraws it.
    assign occupancy        = {1'b0, count} + {1'b0, inflight};
    assign mem_req          = !reset && !redirect && (occupancy < DEPTH_OCC);
    assign mem_addr         = fetch_pc;
    assign req_acc          = mem_req && mem_gnt;
    assign resp             = mem_rvalid && (inflight != '0);
    assign resp_live        = resp && (stale == '0) && !redirect;
    assign fifo_valid       = (count != '0);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef IMEM_PREFETCH_BYPASS_EN
    assign byp_take = resp_live && !fifo_valid;
`else
    assign byp_take = 1'b0;
`endif

    assign inst_valid = fifo_valid || byp_take;
    assign pop        = fifo_valid && inst_ready && !redirect;
    // A bypassed word taken by IF in the same cycle never enters the FIFO.
    assign push       = resp_live && !(byp_take && inst_ready);

    // When empty, the head shows whatever IF saw last.
    always_comb begin
        inst    = hold_inst;
        inst_pc = hold_pc;
        if (fifo_valid) begin
            inst    = fifo_word[rd_ptr];
            inst_pc = fifo_pc[rd_ptr];
        end else if (byp_take) begin
            inst    = mem_rdata;
            inst_pc = resp_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_word[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            inflight  <= '0;
            stale     <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else begin
            if (inst_valid) begin
                hold_inst <= inst;
                hold_pc   <= inst_pc;
            end
            if (redirect) begin
                // Every request still outstanding after this cycle belongs to the old path.
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                inflight <= inflight - CW'(resp);
                stale    <= inflight - CW'(resp);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_acc) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                inflight <= inflight + CW'(req_acc) - CW'(resp);
                if (resp && (stale != '0)) begin
                    stale <= stale - 1'b1;
                end
                if (resp_live) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Bench for imem_prefetch_queue: in-order variable-latency memory driver plus a
// queue-based reference model of fetch, drop and delivery.
module tb_imem_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    imem_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard state
    logic [63:0] exp_q[$];      // buffered {pc, word}
    logic        infl_q[$];     // one flag per outstanding request: 1 = belongs to a flushed path
    logic [31:0] m_fetch, m_resp, m_last_inst, m_last_pc;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_inst, e_pc;
    logic        real_resp;

    // memory model
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc;
    int          lat_min, lat_max;

    int n_vec;
    int n_err;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h8C01};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycle(input logic rst, input logic gnt, input logic rdy,
                             input logic redir, input logic [31:0] rpc);
        logic resp_m, s;
        @(negedge clock);
        reset       = rst;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        // no new grants until responses to requests forgotten by a reset have drained
        mem_gnt     = gnt && (pend_addr.size() <= infl_q.size());
        real_resp   = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
        if (real_resp) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(pend_addr[0]);
        end else begin
            mem_rvalid = (pend_addr.size() == 0) && (infl_q.size() == 0) && ($urandom_range(0, 9) == 0);
            mem_rdata  = $urandom;
        end

        e_req   = !rst && !redir && ((exp_q.size() + infl_q.size()) < DEPTH);
        e_addr  = m_fetch;
        e_valid = (exp_q.size() != 0);
        if (e_valid) {e_pc, e_inst} = exp_q[0];
        else begin
            e_pc   = m_last_pc;
            e_inst = m_last_inst;
        end

        #1;
        check_eq("mem_req", {31'b0, mem_req}, {31'b0, e_req});
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
        check_eq("inst", inst, e_inst);
        check_eq("inst_pc", inst_pc, e_pc);

        @(posedge clock);
        if (rst) begin
            exp_q.delete();
            infl_q.delete();
            m_fetch     = RESET_PC;
            m_resp      = RESET_PC;
            m_last_inst = '0;
            m_last_pc   = '0;
        end else begin
            resp_m = mem_rvalid && (infl_q.size() != 0);
            if (e_valid) begin
                m_last_pc   = e_pc;
                m_last_inst = e_inst;
            end
            if (redir) begin
                exp_q.delete();
                if (resp_m) void'(infl_q.pop_front());
                foreach (infl_q[i]) infl_q[i] = 1'b1;
                m_fetch = {rpc[31:2], 2'b00};
                m_resp  = {rpc[31:2], 2'b00};
            end else begin
                if (e_valid && rdy) void'(exp_q.pop_front());
                if (resp_m) begin
                    s = infl_q.pop_front();
                    if (!s) begin
                        exp_q.push_back({m_resp, mem_rdata});
                        m_resp = m_resp + 32'd4;
                    end
                end
                if (e_req && mem_gnt) begin
                    infl_q.push_back(1'b0);
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
        if (real_resp) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (e_req && mem_gnt) begin
            pend_addr.push_back(e_addr);
            pend_due.push_back(cyc + $urandom_range(lat_min, lat_max));
        end
        cyc++;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            1:       return 32'h0000_0100 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_rand(input int n, input int gnt_pct, input int rdy_pct,
                            input int redir_pct, input int rst_pct);
        for (int i = 0; i < n; i++) begin
            run_cycle($urandom_range(0, 99) < rst_pct, $urandom_range(0, 99) < gnt_pct,
                      $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < redir_pct,
                      pick_target());
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        m_fetch = RESET_PC; m_resp = RESET_PC; m_last_inst = '0; m_last_pc = '0;
        reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        // power-on reset; the model starts from the reset values
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // streaming with a 1-cycle memory
        for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // IF stalled until the queue fills, then drained
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // 3-cycle memory, redirect with requests in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // unaligned target and address wrap
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // back-to-back redirects
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_4000);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_8001);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // reset with requests in flight; their late responses must be ignored
        for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // randomized mix
        lat_min = 1; lat_max = 4;
        run_rand(1500, 70, 60, 4, 1);
        lat_min = 1; lat_max = 1;
        run_rand(800, 90, 90, 3, 0);
        lat_min = 2; lat_max = 5;
        run_rand(800, 50, 30, 5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_prefetch_queue.md
# imem_prefetch_queue

Instruction prefetch queue between the instruction memory and the CPU IF stage. It issues sequential fetch requests to a variable-latency, in-order instruction memory and buffers returned words with their PCs in a small FIFO. It presents them to IF through a valid/ready handshake. On a taken-branch redirect it flushes its contents, discards stale in-flight responses and restarts fetch at the target.

## Interface
- DEPTH, 4: FIFO entries and maximum buffered-plus-in-flight requests; power of two, ≥2
- RESET_PC, 32'h0: first fetch address after reset
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- mem_req  out  1  fetch request valid
- mem_addr  out  32  fetch byte address, word aligned
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response word valid; responses return in request order
- mem_rdata  in  32  response instruction word
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced 0
- inst_valid  out  1  head entry valid
- inst_ready  in  1  IF stage consumes head this cycle
- inst  out  32  head instruction word
- inst_pc  out  32  PC of head instruction

## Operation
- State:
  - fetch_pc (32): next address to request.
  - resp_pc (32): PC of next non-stale response.
  - inflight: accepted, unanswered requests.
  - stale: leading inflight requests to drop.
  - FIFO of {pc, word}, count 0..DEPTH.
  - Counters are clog2(DEPTH)+1 bits.
- mem_req = !reset && !redirect && (count + inflight < DEPTH). mem_addr = fetch_pc.
- Request accepted (mem_req && mem_gnt):
  - fetch_pc += 4, wrapping modulo 2^32.
  - inflight++.
- Response (mem_rvalid && inflight != 0):
  - inflight--.
  - If stale != 0: stale--, data dropped.
  - Else: push {resp_pc, mem_rdata}; resp_pc += 4.
  - mem_rvalid with inflight == 0 is ignored.
- Pop when inst_valid && inst_ready. Push and pop may occur in the same cycle. Credit rule guarantees a push never finds the FIFO full.
- redirect (overrides pop):
  - FIFO cleared.
  - fetch_pc and resp_pc ← {redirect_pc[31:2], 2'b00}.
  - stale ← inflight − (mem_rvalid ? 1 : 0). A response in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
- mem_req may drop without a grant only on redirect or reset; otherwise mem_req and mem_addr are held until mem_gnt.

## Timing
- Reset values:
  - mem_req=0, inst_valid=0, inst=0, inst_pc=0.
  - fetch_pc=resp_pc=RESET_PC.
  - inflight=stale=count=0.
- First cycle after reset deasserts: mem_req=1, mem_addr=RESET_PC.
- Latency: a response accepted in cycle N appears as inst_valid in cycle N+1 (registered FIFO, first-word-fall-through head).
- Throughput: one request and one instruction per cycle with a 1-cycle memory and inst_ready held high, provided DEPTH ≥ memory latency + 1.
- Full: count + inflight == DEPTH → mem_req=0. A pop or drop in cycle N allows a request in cycle N+1.
- Empty: inst_valid=0. inst and inst_pc hold their last values.
- Reset mid-operation: all state cleared. Late responses from pre-reset requests hit inflight==0 and are ignored.
- Back-to-back redirects: each recomputes stale from current inflight; the last target wins.

## Configuration
- IMEM_PREFETCH_BYPASS_EN defined:
  - When count==0, stale==0, !redirect and a response arrives, inst_valid=1 in the same cycle with inst=mem_rdata and inst_pc=resp_pc (combinational path).
  - If inst_ready is also 1, the word is consumed and not written to the FIFO.
  - Otherwise it is written as normal.
- Not defined: 1-cycle response-to-inst_valid latency as specified above; no combinational path from memory to IF.

## Test plan
- Reset, 1-cycle memory, inst_ready=1 → requests at 0x0, 0x4, 0x8…; inst_pc 0x0, 0x4… one per cycle, first inst_valid 2 cycles after first grant.
- inst_ready=0, DEPTH=4, 1-cycle memory → exactly 4 grants then mem_req=0. Raise inst_ready → 4 instructions in order, then fetch resumes at 0x10.
- 3 requests in flight (3-cycle memory), redirect to 0x100 → next 3 responses dropped, mem_addr=0x100 the following cycle, first inst_pc=0x100.
- Redirect to 0x203 → fetch at 0x200. fetch_pc 0xFFFFFFFC → next request address 0x00000000.
- Reset asserted with 2 in flight; responses arrive after release → ignored, first inst_pc=RESET_PC.
- IMEM_PREFETCH_BYPASS_EN defined, FIFO empty, response 0x8C010004 with inst_ready=1 → inst_valid=1 and inst=0x8C010004 in the same cycle, count stays 0.
